cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Round-robin arbiter that shares the common data bus (CDB) between the execution units (reservation-station/functional-unit pairs) that complete instructions. Each cycle it selects at most one completed result and broadcasts it as `cdb_valid_o`/`cdb_data_o` to the reorder buffer and to the reservation stations. Fairness comes from a rotating priority pointer. An optional output register breaks the timing path between the execution units and the CDB consumers.

## Interface
- `N_REQ`, default 4: number of requesters; must be ≥ 2.
- `clk_i` in 1: clock.
- `rst_n_i` in 1: asynchronous active-low reset.
- `flush_i` in 1: synchronous pipeline flush.
- `fu_valid_i` in `N_REQ`: requester i holds a completed result.
- `fu_ready_o` out `N_REQ`: requester i's result is accepted this cycle.
- `fu_data_i` in `N_REQ` × `cdb_data_t`: per-requester result (`rob_idx`, `value`, `except_raised`, `except_code`).
- `cdb_valid_o` out 1: CDB carries a valid result.
- `cdb_ready_i` in 1: CDB consumers accept the result.
- `cdb_data_o` out `cdb_data_t`: broadcast result.

## Operation
- Priority pointer `prio_q` is `$clog2(N_REQ)` bits wide and resets to 0.
- Grant selection:
  - Search for the first asserted `fu_valid_i[k]` with k = `prio_q`, `prio_q`+1, … mod `N_REQ`.
  - The grant is one-hot and is all-zero when no request is asserted.
- Accept condition: a requester's handshake is `fu_valid_i[g] && fu_ready_o[g]`. At most one `fu_ready_o` bit is high in any cycle.
- Pointer update:
  - On a handshake with requester g, `prio_q` ← (g+1) mod `N_REQ`. When g = `N_REQ`−1, the pointer wraps to 0.
  - With no handshake, `prio_q` holds.
- Ready gating:
  - `fu_ready_o` is forced to 0 while `flush_i` is asserted.
  - A flush also resets `prio_q` to 0.
- Requesters must hold `fu_valid_i` and `fu_data_i` stable until accepted. The arbiter never drops a granted-but-unaccepted result.
- Consumer contract: no stall is expected from the reorder buffer. `cdb_ready_i` exists for consumers that do stall, and the arbiter honours it fully.

## Timing
- Reset values:
  - `cdb_valid_o` = 0.
  - `cdb_data_o` = 0.
  - `prio_q` = 0.
  - `fu_ready_o` = 0 whenever `fu_valid_i` = 0.
- Pass-through mode (macro undefined):
  - `cdb_valid_o` = OR of `fu_valid_i`, masked by `!flush_i`.
  - `cdb_data_o` = `fu_data_i` of the granted requester.
  - `fu_ready_o[g]` = `grant[g] && cdb_ready_i && !flush_i`.
  - Latency is 0 cycles.
- Registered mode (macro defined):
  - Output register `out_valid_q`/`out_data_q` has load enable `load_en` = `!out_valid_q || cdb_ready_i`.
  - `fu_ready_o[g]` = `grant[g] && load_en && !flush_i`.
  - On a handshake, the register loads the winner's data and `out_valid_q` ← 1.
  - When the register is emptied by `cdb_ready_i` with no new handshake, `out_valid_q` ← 0.
  - Latency is 1 cycle from the requester handshake to `cdb_valid_o`. Full throughput of 1 result per cycle is sustained when `cdb_ready_i` = 1.
  - While `cdb_valid_o && !cdb_ready_i`, `cdb_data_o` is stable and `fu_ready_o` = 0.
  - `flush_i` clears `out_valid_q` on the next edge, with priority over load.
- Reset asserted mid-operation: the register and pointer return to their reset values immediately (asynchronously). Any in-flight result is discarded.
- Simultaneous flush and handshake: impossible by construction, because `fu_ready_o` is gated by `!flush_i`.

## Configuration
- Macro: `LEN5_CDB_OUT_REG_EN`.
- Defined: the registered output stage is instantiated, giving 1-cycle latency and backpressure held in the output register.
- Undefined: combinational pass-through with 0-cycle latency. The arbiter holds no state other than `prio_q`.
- Grant fairness and pointer rules are identical in both modes.

## Test plan
- Reset, then `fu_valid_i` = 4'b0000 for 5 cycles → `cdb_valid_o` = 0, `fu_ready_o` = 0, `prio_q` = 0.
- `fu_valid_i` = 4'b1111 held, `cdb_ready_i` = 1 → grants in order 0,1,2,3,0. In registered mode, `cdb_data_o.rob_idx` follows one cycle later.
- `prio_q` = 2 and `fu_valid_i` = 4'b0011 → requester 0 is granted, then `prio_q` = 1 and requester 1 is granted next.
- Registered mode: load `rob_idx` = 5, drop `cdb_ready_i` for 3 cycles → `cdb_data_o.rob_idx` stays 5, `fu_ready_o` = 0 throughout, the pending requester is accepted on the cycle `cdb_ready_i` returns to 1, and no result is duplicated or lost.
- Registered mode: `flush_i` pulsed while `cdb_valid_o` = 1 → `cdb_valid_o` = 0 on the next cycle, `fu_ready_o` = 0 during the flush, and `prio_q` = 0 afterwards.
- Assert `rst_n_i` = 0 mid-stream with `cdb_valid_o` = 1 → outputs return to 0 asynchronously, and the first grant after release goes to the lowest-index valid requester.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter sharing the common data bus among N_REQ execution units.
// Ports:
//   clk_i, rst_n_i         clock, asynchronous active-low reset
//   flush_i                synchronous pipeline flush (blocks accepts, resets priority)
//   fu_valid_i/fu_ready_o  per-requester completed-result handshake
//   fu_data_i              per-requester result word
//   cdb_valid_o/cdb_ready_i/cdb_data_o  broadcast result towards ROB and reservation stations
// Result word layout (MSB..LSB): {rob_idx[ROB_W], value[VAL_W], except_raised, except_code[EXC_W]}.
// Define LEN5_CDB_OUT_REG_EN to insert the output register (1-cycle latency); otherwise pass-through.
module cdb_arbiter #(
  parameter int N_REQ = 4,
  parameter int ROB_W = 4,
  parameter int VAL_W = 32,
  parameter int EXC_W = 5,
  localparam int DATA_W = ROB_W + VAL_W + 1 + EXC_W,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           flush_i,
  input  logic [N_REQ-1:0]               fu_valid_i,
  output logic [N_REQ-1:0]               fu_ready_o,
  input  logic [N_REQ-1:0][DATA_W-1:0]   fu_data_i,
  output logic                           cdb_valid_o,
  input  logic                           cdb_ready_i,
  output logic [DATA_W-1:0]              cdb_data_o
);
  logic [PTR_W-1:0]  prio_q, prio_d, gnt_idx, cand;
  logic              any_req, hs, accept_en;
  logic [N_REQ-1:0]  grant;
  logic [DATA_W-1:0] sel_data;
  // Scan from the highest rotated offset down so the last hit is the one closest to prio_q.
  always_comb begin
    gnt_idx = '0;
    any_req = 1'b0;
    cand = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = PTR_W'((int'(prio_q) + k) % N_REQ);
      if (fu_valid_i[cand]) begin
        gnt_idx = cand;
        any_req = 1'b1;
      end
    end
  end
  assign grant      = any_req ? N_REQ'(1) << gnt_idx : '0;
  assign sel_data   = fu_data_i[gnt_idx];
  assign fu_ready_o = grant & {N_REQ{accept_en}};
  assign hs         = |(fu_valid_i & fu_ready_o);
  always_comb begin
    prio_d = flush_i ? '0 : !hs ? prio_q : (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) prio_q <= '0;
    else          prio_q <= prio_d;
  end
`ifdef LEN5_CDB_OUT_REG_EN
  logic              out_valid_q, out_valid_d, load_en;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  // The register may take a new result when empty or when it drains this cycle.
  assign load_en   = !out_valid_q || cdb_ready_i;
  assign accept_en = load_en && !flush_i && rst_n_i;
  always_comb begin
    out_valid_d = flush_i ? 1'b0 : hs ? 1'b1 : cdb_ready_i ? 1'b0 : out_valid_q;
    out_data_d  = hs ? sel_data : out_data_q;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end
  assign cdb_valid_o = out_valid_q;
  assign cdb_data_o  = out_data_q;
`else
  // Reset also masks the combinational path so nothing is broadcast or accepted while held.
  assign accept_en   = cdb_ready_i && !flush_i && rst_n_i;
  assign cdb_valid_o = any_req && !flush_i && rst_n_i;
  assign cdb_data_o  = (any_req && rst_n_i) ? sel_data : '0;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard bench for the CDB round-robin arbiter (pass-through or registered build).
module tb_cdb_arbiter;
  localparam int N = 4;
  localparam int DW = 42;
`ifdef LEN5_CDB_OUT_REG_EN
  localparam bit REG = 1'b1;
`else
  localparam bit REG = 1'b0;
`endif
  logic                 clk_i = 1'b0;
  logic                 rst_n_i = 1'b0;
  logic                 flush_i = 1'b0;
  logic                 cdb_ready_i = 1'b1;
  logic                 cdb_valid_o;
  logic [N-1:0]         fu_valid_i = '0;
  logic [N-1:0]         fu_ready_o;
  logic [N-1:0][DW-1:0] fu_data_i = '0;
  logic [DW-1:0]        cdb_data_o;
  logic [DW-1:0]        exp_d;
  logic [DW-1:0]        sb[$];
  int                   checks = 0;
  int                   errors = 0;
  int                   m_prio = 0;
  bit                   m_ov = 1'b0;

  cdb_arbiter #(.N_REQ(N)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .fu_valid_i(fu_valid_i), .fu_ready_o(fu_ready_o), .fu_data_i(fu_data_i),
    .cdb_valid_o(cdb_valid_o), .cdb_ready_i(cdb_ready_i), .cdb_data_o(cdb_data_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  function automatic logic [DW-1:0] mk(input logic [3:0] rob);
    logic [31:0] v;
    v = $urandom;
    return {rob, v, 1'b0, 5'd0};
  endfunction

  function automatic int exp_win(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic adv;
    @(posedge clk_i);
    #1;
  endtask

  // Reference model step: predicts this cycle's accept, pushes the accepted word, advances model state.
  task automatic tick(output logic [N-1:0] er);
    int w;
    bit le;
    @(negedge clk_i);
    w = exp_win(fu_valid_i, m_prio);
    le = REG ? (!m_ov || cdb_ready_i) : cdb_ready_i;
    er = '0;
    if (w >= 0 && le && !flush_i && rst_n_i) er[w] = 1'b1;
    if (REG && flush_i && m_ov && !cdb_ready_i) sb.delete();
    if (er != '0) begin
      sb.push_back(fu_data_i[w]);
      m_prio = (w + 1) % N;
    end else if (flush_i) m_prio = 0;
    m_ov = flush_i ? 1'b0 : (er != '0) ? 1'b1 : cdb_ready_i ? 1'b0 : m_ov;
  endtask

  always @(negedge clk_i) begin
    #1;
    if (rst_n_i && cdb_valid_o && cdb_ready_i) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL cdb_extra: got transfer %h expected none", cdb_data_o);
      end else begin
        exp_d = sb.pop_front();
        if (cdb_data_o !== exp_d) begin
          errors++;
          $display("FAIL cdb_data: got %h expected %h", cdb_data_o, exp_d);
        end
      end
    end
  end

  task automatic drain;
    logic [N-1:0] er;
    fu_valid_i = '0;
    flush_i = 1'b0;
    cdb_ready_i = 1'b1;
    repeat (2) begin
      tick(er);
      adv();
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic test_reset;
    logic [N-1:0] er;
    rst_n_i = 1'b0;
    repeat (2) adv();
    rst_n_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick(er);
      checks++;
      if (cdb_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", cdb_valid_o); end
      checks++;
      if (fu_ready_o !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", fu_ready_o); end
      checks++;
      if (dut.prio_q !== 2'd0) begin errors++; $display("FAIL reset_prio: got %0d expected 0", dut.prio_q); end
      adv();
    end
  endtask

  task automatic test_round_robin;
    logic [N-1:0] er;
    int seq[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] want;
    for (int i = 0; i < N; i++) fu_data_i[i] = mk(4'(i + 1));
    fu_valid_i = 4'b1111;
    cdb_ready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick(er);
      want = '0;
      want[seq[c]] = 1'b1;
      checks++;
      if (fu_ready_o !== want) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", c, fu_ready_o, want); end
      adv();
    end
    drain();
  endtask

  task automatic test_wrap;
    logic [N-1:0] er;
    fu_data_i[1] = mk(4'd3);
    fu_valid_i = 4'b0010;
    tick(er);
    checks++;
    if (fu_ready_o !== 4'b0010) begin errors++; $display("FAIL wrap_pre: got %b expected 0010", fu_ready_o); end
    adv();
    checks++;
    if (dut.prio_q !== 2'd2) begin errors++; $display("FAIL wrap_prio2: got %0d expected 2", dut.prio_q); end
    fu_data_i[0] = mk(4'd6);
    fu_data_i[1] = mk(4'd7);
    fu_valid_i = 4'b0011;
    tick(er);
    checks++;
    if (fu_ready_o !== 4'b0001) begin errors++; $display("FAIL wrap_g0: got %b expected 0001", fu_ready_o); end
    adv();
    checks++;
    if (dut.prio_q !== 2'd1) begin errors++; $display("FAIL wrap_prio1: got %0d expected 1", dut.prio_q); end
    tick(er);
    checks++;
    if (fu_ready_o !== 4'b0010) begin errors++; $display("FAIL wrap_g1: got %b expected 0010", fu_ready_o); end
    adv();
    drain();
  endtask

  task automatic test_stall;
    logic [N-1:0] er;
    logic [3:0] rob;
    fu_data_i[0] = mk(4'd5);
    fu_valid_i = 4'b0001;
    cdb_ready_i = 1'b1;
    tick(er);
    checks++;
    if (fu_ready_o !== 4'b0001) begin errors++; $display("FAIL stall_load: got %b expected 0001", fu_ready_o); end
    adv();
    fu_data_i[2] = mk(4'd9);
    fu_valid_i = 4'b0100;
    cdb_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick(er);
      rob = cdb_data_o[DW-1 -: 4];
      checks++;
      if (fu_ready_o !== 4'b0000) begin errors++; $display("FAIL stall_ready%0d: got %b expected 0000", c, fu_ready_o); end
      checks++;
      if (cdb_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid%0d: got %b expected 1", c, cdb_valid_o); end
      checks++;
      if (rob !== (REG ? 4'd5 : 4'd9)) begin errors++; $display("FAIL stall_rob%0d: got %0d expected %0d", c, rob, REG ? 5 : 9); end
      adv();
    end
    cdb_ready_i = 1'b1;
    tick(er);
    checks++;
    if (fu_ready_o !== 4'b0100) begin errors++; $display("FAIL stall_resume: got %b expected 0100", fu_ready_o); end
    adv();
    drain();
  endtask

  task automatic test_flush;
    logic [N-1:0] er;
    fu_data_i[1] = mk(4'd11);
    fu_valid_i = 4'b0010;
    cdb_ready_i = 1'b1;
    tick(er);
    checks++;
    if (fu_ready_o !== 4'b0010) begin errors++; $display("FAIL flush_load: got %b expected 0010", fu_ready_o); end
    adv();
    flush_i = 1'b1;
    fu_data_i[3] = mk(4'd12);
    fu_valid_i = 4'b1000;
    cdb_ready_i = 1'b0;
    tick(er);
    checks++;
    if (fu_ready_o !== 4'b0000) begin errors++; $display("FAIL flush_ready: got %b expected 0000", fu_ready_o); end
    checks++;
    if (cdb_valid_o !== REG) begin errors++; $display("FAIL flush_valid_during: got %b expected %b", cdb_valid_o, REG); end
    adv();
    flush_i = 1'b0;
    fu_valid_i = 4'b0000;
    cdb_ready_i = 1'b1;
    tick(er);
    checks++;
    if (cdb_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid_after: got %b expected 0", cdb_valid_o); end
    checks++;
    if (dut.prio_q !== 2'd0) begin errors++; $display("FAIL flush_prio: got %0d expected 0", dut.prio_q); end
    adv();
    fu_data_i[1] = mk(4'd13);
    fu_data_i[2] = mk(4'd14);
    fu_valid_i = 4'b0110;
    tick(er);
    checks++;
    if (fu_ready_o !== 4'b0010) begin errors++; $display("FAIL flush_regrant: got %b expected 0010", fu_ready_o); end
    adv();
    drain();
  endtask

  task automatic test_reset_mid;
    logic [N-1:0] er;
    for (int i = 0; i < N; i++) fu_data_i[i] = mk(4'(8 + i));
    fu_valid_i = 4'b1111;
    cdb_ready_i = 1'b1;
    tick(er);
    adv();
    rst_n_i = 1'b0;
    sb.delete();
    m_prio = 0;
    m_ov = 1'b0;
    #2;
    checks++;
    if (cdb_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", cdb_valid_o); end
    checks++;
    if (cdb_data_o !== '0) begin errors++; $display("FAIL rst_mid_data: got %h expected 0", cdb_data_o); end
    checks++;
    if (fu_ready_o !== 4'b0000) begin errors++; $display("FAIL rst_mid_ready: got %b expected 0000", fu_ready_o); end
    checks++;
    if (dut.prio_q !== 2'd0) begin errors++; $display("FAIL rst_mid_prio: got %0d expected 0", dut.prio_q); end
    fu_valid_i = 4'b1100;
    adv();
    rst_n_i = 1'b1;
    tick(er);
    checks++;
    if (fu_ready_o !== 4'b0100) begin errors++; $display("FAIL rst_first_grant: got %b expected 0100", fu_ready_o); end
    adv();
    drain();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_wrap();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
